multi_rule_monitor: RTL and testbench

Synthesisable, parametrised multi-channel implication checker: per channel, "if `sig_a` is seen while `sig_b` is inactive, then `sig_c` must be inactive and `sig_b` asserted after a programmed delay or within a window".
- Sits beside the DUT in emulation and silicon-debug builds, where bind-time SVA is unavailable.
- Reports per-cycle pass/fail pulses, saturating totals, a sticky error, and first-failure capture.

---
 rtl/multi_rule_monitor_pkg.sv | 29 ++
 rtl/multi_rule_monitor_if.sv | 40 ++++
 rtl/multi_rule_monitor_chan.sv | 67 ++++++
 rtl/multi_rule_monitor.sv | 138 +++++++++++++
 tb/tb_multi_rule_monitor.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/multi_rule_monitor_pkg.sv
// Shared types and the configuration legality check for multi_rule_monitor.
package multi_rule_monitor_pkg;

   // Wide enough for any supported MAX_DLY (up to 16).
   localparam int CFG_DW = 5;

   typedef enum logic {
      MODE_EXACT  = 1'b0,
      MODE_WINDOW = 1'b1
   } mode_e;

   typedef struct packed {
      mode_e             mode;
      logic [CFG_DW-1:0] dly_min;
      logic [CFG_DW-1:0] dly_max;
   } mon_cfg_t;

   // A configuration is usable when the delay fits the age vector and,
   // in window mode, the lower bound is non-zero and not above the upper.
   function automatic logic cfg_legal(input mon_cfg_t cfg, input int max_dly);
      logic ok;
      ok = (cfg.dly_max != '0) && (int'(cfg.dly_max) <= max_dly);
      if (cfg.mode == MODE_WINDOW) begin
         ok = ok && (cfg.dly_min != '0) && (cfg.dly_min <= cfg.dly_max);
      end
      return ok;
   endfunction

endpackage

// File: rtl/multi_rule_monitor_if.sv
// Bundle of configuration, monitored signals and results for multi_rule_monitor.
interface multi_rule_monitor_if #(
   parameter int NCH     = 4,
   parameter int MAX_DLY = 4,
   parameter int CNT_W   = 16,
   parameter int TS_W    = 32
);
   localparam int DW  = $clog2(MAX_DLY + 1);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

   logic           en;
   logic           mode;
   logic [DW-1:0]  dly_min;
   logic [DW-1:0]  dly_max;
   logic           clr;
   logic [NCH-1:0] sig_a;
   logic [NCH-1:0] sig_b;
   logic [NCH-1:0] sig_c;

   logic [NCH-1:0]   pass_pulse;
   logic [NCH-1:0]   fail_pulse;
   logic [CNT_W-1:0] pass_cnt;
   logic [CNT_W-1:0] fail_cnt;
   logic             err_sticky;
   logic [CHW-1:0]   first_fail_ch;
   logic [TS_W-1:0]  first_fail_ts;
   logic             cfg_err;

   modport master (
      output en, mode, dly_min, dly_max, clr, sig_a, sig_b, sig_c,
      input  pass_pulse, fail_pulse, pass_cnt, fail_cnt, err_sticky,
             first_fail_ch, first_fail_ts, cfg_err
   );

   modport slave (
      input  en, mode, dly_min, dly_max, clr, sig_a, sig_b, sig_c,
      output pass_pulse, fail_pulse, pass_cnt, fail_cnt, err_sticky,
             first_fail_ch, first_fail_ts, cfg_err
   );
endinterface

// File: rtl/multi_rule_monitor_chan.sv
// One channel of the implication checker: tracks pending attempts by age
// and reports how many resolved as pass or fail on the current edge.
module rule_mon_chan
   import multi_rule_monitor_pkg::*;
#(
   parameter int MAX_DLY = 4,
   parameter int CW      = $clog2(MAX_DLY + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          active_i,   // en high and effective config legal
   input  mon_cfg_t      cfg_i,
   input  logic          a_i,
   input  logic          b_i,
   input  logic          c_i,
   output logic [CW-1:0] pass_n_o,
   output logic [CW-1:0] fail_n_o
);

   // Bit j of pend_q is an attempt that has age j+1 at the current edge.
   logic [MAX_DLY-1:0] pend_q, pend_d;
   logic [MAX_DLY-1:0] in_win, at_hi;
   logic [MAX_DLY-1:0] pass_mask, fail_mask;
   logic               good, trig;

   // Age masks against the effective configuration.
   generate
      for (genvar gi = 0; gi < MAX_DLY; gi++) begin : g_age
         localparam logic [CFG_DW-1:0] AGE = CFG_DW'(gi + 1);
         assign in_win[gi] = (AGE >= cfg_i.dly_min) && (AGE <= cfg_i.dly_max);
         assign at_hi[gi]  = (AGE == cfg_i.dly_max);
      end
   endgenerate

   assign good = ~c_i & b_i;
   assign trig = active_i & a_i & ~b_i;

   // Resolve pending attempts, then age the survivors and add a new trigger.
   always_comb begin
      pass_mask = '0;
      fail_mask = '0;
      pend_d    = '0;
      pass_n_o  = '0;
      fail_n_o  = '0;
      if (active_i) begin
         if (cfg_i.mode == MODE_WINDOW) begin
            if (good) pass_mask = pend_q & in_win;
            else      fail_mask = pend_q & at_hi;
         end else begin
            if (good) pass_mask = pend_q & at_hi;
            else      fail_mask = pend_q & at_hi;
         end
         pend_d = ((pend_q & ~(pass_mask | fail_mask)) << 1) | (MAX_DLY)'(trig);
      end
      for (int j = 0; j < MAX_DLY; j++) begin
         pass_n_o = pass_n_o + CW'(pass_mask[j]);
         fail_n_o = fail_n_o + CW'(fail_mask[j]);
      end
   end

   // Pending age vector; disabling flushes it through pend_d = 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend_q <= '0;
      else        pend_q <= pend_d;
   end

endmodule

// File: rtl/multi_rule_monitor.sv
// Multi-channel implication monitor: config shadowing, per-channel checkers,
// saturating totals, sticky error and first-failure capture.
module multi_rule_monitor
   import multi_rule_monitor_pkg::*;
#(
   parameter int NCH     = 4,
   parameter int MAX_DLY = 4,
   parameter int CNT_W   = 16,
   parameter int TS_W    = 32
) (
   input logic clk,
   input logic rst_n,
   multi_rule_monitor_if.slave mon_if
);
   localparam int CW  = $clog2(MAX_DLY + 1);
   localparam int SW  = $clog2(NCH * MAX_DLY + 1);
   localparam int AW  = CNT_W + SW;
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

   logic             en_q;
   mon_cfg_t         cfg_q;
   logic             cfg_err_q;
   logic [TS_W-1:0]  ts_q;
   logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
   logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
   logic             err_sticky_q;
   logic [CHW-1:0]   ff_ch_q;
   logic [TS_W-1:0]  ff_ts_q;
   logic [NCH-1:0]   pass_pulse_q, fail_pulse_q;

   mon_cfg_t         cfg_in, cfg_eff;
   logic             en_rise, active;
   logic [CW-1:0]    pass_n [NCH];
   logic [CW-1:0]    fail_n [NCH];
   logic [NCH-1:0]   pass_hit, fail_hit;
   logic [SW-1:0]    pass_sum, fail_sum;
   logic [AW-1:0]    pass_wide, fail_wide;
   logic [CHW-1:0]   first_ch;

   assign cfg_in.mode    = mode_e'(mon_if.mode);
   assign cfg_in.dly_min = CFG_DW'(mon_if.dly_min);
   assign cfg_in.dly_max = CFG_DW'(mon_if.dly_max);

   // The enabling edge already checks with the incoming configuration.
   assign en_rise = mon_if.en & ~en_q;
   assign cfg_eff = en_rise ? cfg_in : cfg_q;
   assign active  = mon_if.en & cfg_legal(cfg_eff, MAX_DLY);

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
         rule_mon_chan #(.MAX_DLY(MAX_DLY), .CW(CW)) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .active_i (active),
            .cfg_i    (cfg_eff),
            .a_i      (mon_if.sig_a[gi]),
            .b_i      (mon_if.sig_b[gi]),
            .c_i      (mon_if.sig_c[gi]),
            .pass_n_o (pass_n[gi]),
            .fail_n_o (fail_n[gi])
         );
         assign pass_hit[gi] = |pass_n[gi];
         assign fail_hit[gi] = |fail_n[gi];
      end
   endgenerate

   // Sum resolved attempts, saturate the totals and pick the lowest failing channel.
   always_comb begin
      pass_sum = '0;
      fail_sum = '0;
      first_ch = '0;
      for (int j = 0; j < NCH; j++) begin
         pass_sum = pass_sum + SW'(pass_n[j]);
         fail_sum = fail_sum + SW'(fail_n[j]);
      end
      for (int j = NCH - 1; j >= 0; j--) begin
         if (fail_hit[j]) first_ch = CHW'(j);
      end
      pass_wide  = AW'(pass_cnt_q) + AW'(pass_sum);
      fail_wide  = AW'(fail_cnt_q) + AW'(fail_sum);
      pass_cnt_d = (pass_wide > AW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : pass_wide[CNT_W-1:0];
      fail_cnt_d = (fail_wide > AW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : fail_wide[CNT_W-1:0];
   end

   // Config shadow, timestamp, pulses, totals and first-failure capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q         <= 1'b0;
         cfg_q        <= '0;
         cfg_err_q    <= 1'b0;
         ts_q         <= '0;
         pass_pulse_q <= '0;
         fail_pulse_q <= '0;
         pass_cnt_q   <= '0;
         fail_cnt_q   <= '0;
         err_sticky_q <= 1'b0;
         ff_ch_q      <= '0;
         ff_ts_q      <= '0;
      end else begin
         en_q         <= mon_if.en;
         ts_q         <= ts_q + TS_W'(1);
         pass_pulse_q <= pass_hit;
         fail_pulse_q <= fail_hit;
         if (en_rise) begin
            cfg_q     <= cfg_in;
            cfg_err_q <= ~cfg_legal(cfg_in, MAX_DLY);
         end
         // Clear wins over this edge's results; pending attempts carry on.
         if (mon_if.clr) begin
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            err_sticky_q <= 1'b0;
            ff_ch_q      <= '0;
            ff_ts_q      <= '0;
         end else begin
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            if (|fail_hit) begin
               err_sticky_q <= 1'b1;
               if (!err_sticky_q) begin
                  ff_ch_q <= first_ch;
                  ff_ts_q <= ts_q;
               end
            end
         end
      end
   end

   assign mon_if.pass_pulse    = pass_pulse_q;
   assign mon_if.fail_pulse    = fail_pulse_q;
   assign mon_if.pass_cnt      = pass_cnt_q;
   assign mon_if.fail_cnt      = fail_cnt_q;
   assign mon_if.err_sticky    = err_sticky_q;
   assign mon_if.first_fail_ch = ff_ch_q;
   assign mon_if.first_fail_ts = ff_ts_q;
   assign mon_if.cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_multi_rule_monitor.sv
// Directed, table-driven bench for multi_rule_monitor.
module tb_multi_rule_monitor;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   multi_rule_monitor_if #(.NCH(4), .MAX_DLY(4), .CNT_W(16), .TS_W(32)) ia ();
   multi_rule_monitor_if #(.NCH(1), .MAX_DLY(4), .CNT_W(2),  .TS_W(32)) ib ();

   multi_rule_monitor #(.NCH(4), .MAX_DLY(4), .CNT_W(16), .TS_W(32)) dut_a (
      .clk(clk), .rst_n(rst_n), .mon_if(ia.slave)
   );
   multi_rule_monitor #(.NCH(1), .MAX_DLY(4), .CNT_W(2), .TS_W(32)) dut_b (
      .clk(clk), .rst_n(rst_n), .mon_if(ib.slave)
   );

   typedef struct {
      logic        en, mode;
      logic [2:0]  dmin, dmax;
      logic        clr;
      logic [3:0]  a, b, c;
      logic [3:0]  pp, fp;
      logic [15:0] pc, fc;
      logic        st;
      logic [1:0]  ch;
      logic [31:0] ts;
      logic        ce;
      logic        chkp;   // 0: pulse outputs not compared on this row
   } vec_t;

   vec_t vq[$];
   int   checks = 0;
   int   passed = 0;

   task automatic add(input logic en, input logic mode, input int dmin, input int dmax,
                      input logic clr, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] pp, input logic [3:0] fp,
                      input int pc, input int fc, input logic st, input int ch,
                      input int ts, input logic ce, input logic chkp);
      vec_t v;
      v.en = en; v.mode = mode; v.dmin = 3'(dmin); v.dmax = 3'(dmax); v.clr = clr;
      v.a = a; v.b = b; v.c = c; v.pp = pp; v.fp = fp;
      v.pc = 16'(pc); v.fc = 16'(fc); v.st = st; v.ch = 2'(ch); v.ts = 32'(ts);
      v.ce = ce; v.chkp = chkp;
      vq.push_back(v);
   endtask

   task automatic drive_a(input vec_t v);
      ia.en = v.en; ia.mode = v.mode; ia.dly_min = v.dmin; ia.dly_max = v.dmax;
      ia.clr = v.clr; ia.sig_a = v.a; ia.sig_b = v.b; ia.sig_c = v.c;
   endtask

   task automatic check_a(input string nm, input vec_t v);
      logic [75:0] act, exp, msk;
      act = {ia.pass_pulse, ia.fail_pulse, ia.pass_cnt, ia.fail_cnt, ia.err_sticky,
             ia.first_fail_ch, ia.first_fail_ts, ia.cfg_err};
      exp = {v.pp, v.fp, v.pc, v.fc, v.st, v.ch, v.ts, v.ce};
      msk = v.chkp ? {76{1'b1}} : {8'h00, {68{1'b1}}};
      checks++;
      if ((act & msk) !== (exp & msk))
         $display("FAIL %s: pp_fp_pc_fc_st_ch_ts_ce got %h required %h (mask %h)",
                  nm, act, exp, msk);
      else
         passed++;
   endtask

   task automatic check_val(input string nm, input logic [63:0] got, input logic [63:0] req);
      checks++;
      if (got !== req) $display("FAIL %s: got %0h required %0h", nm, got, req);
      else             passed++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   vec_t zero_v;

   initial begin
      ia.en = 0; ia.mode = 0; ia.dly_min = 0; ia.dly_max = 0; ia.clr = 0;
      ia.sig_a = 0; ia.sig_b = 0; ia.sig_c = 0;
      ib.en = 0; ib.mode = 0; ib.dly_min = 0; ib.dly_max = 0; ib.clr = 0;
      ib.sig_a = 0; ib.sig_b = 0; ib.sig_c = 0;
      zero_v = '{default: '0};
      zero_v.chkp = 1'b1;

      // Row r is applied at edge Er (first edge after reset release is E0).
      //   en m mn mx clr  a     b     c      pp    fp    pc fc st ch ts ce chkp
      add(0,0,0,0,0, 4'h0,4'h0,4'h0, 4'h0,4'h0, 0,0,0,0,0, 0,1); // r0
      add(1,0,0,1,0, 4'h0,4'h0,4'h0, 4'h0,4'h0, 0,0,0,0,0, 0,1); // r1 exact D=1
      add(1,0,0,1,0, 4'h0,4'h0,4'h0, 4'h0,4'h0, 0,0,0,0,0, 0,1);
      add(1,0,0,1,0, 4'h1,4'h0,4'h0, 4'h0,4'h0, 0,0,0,0,0, 0,1); // r3 trigger
      add(1,0,0,1,0, 4'h0,4'h0,4'h1, 4'h0,4'h1, 0,1,1,0,4, 0,1); // r4 fail
      add(1,0,0,1,0, 4'h0,4'h0,4'h0, 4'h0,4'h0, 0,1,1,0,4, 0,1);
      add(1,0,0,1,0, 4'h1,4'h0,4'h0, 4'h0,4'h0, 0,1,1,0,4, 0,1); // r6 trigger
      add(1,0,0,1,0, 4'h0,4'h1,4'h0, 4'h1,4'h0, 1,1,1,0,4, 0,1); // r7 pass
      add(1,0,0,1,0, 4'h0,4'h0,4'h0, 4'h0,4'h0, 1,1,1,0,4, 0,1);
      add(0,0,0,1,0, 4'h0,4'h0,4'h0, 4'h0,4'h0, 1,1,1,0,4, 0,1); // r9 disable
      add(1,1,2,4,0, 4'h1,4'h0,4'h0, 4'h0,4'h0, 1,1,1,0,4, 0,1); // r10 window 2..4 + trig
      add(1,1,2,4,0, 4'h0,4'h1,4'h0, 4'h0,4'h0, 1,1,1,0,4, 0,1); // r11 good at age 1
      add(1,1,2,4,0, 4'h0,4'h0,4'h0, 4'h0,4'h0, 1,1,1,0,4, 0,1);
      add(1,1,2,4,0, 4'h0,4'h0,4'h0, 4'h0,4'h0, 1,1,1,0,4, 0,1);
      add(1,1,2,4,0, 4'h0,4'h0,4'h0, 4'h0,4'h1, 1,2,1,0,4, 0,1); // r14 fail at hi
      add(1,1,2,4,0, 4'h2,4'h0,4'h0, 4'h0,4'h0, 1,2,1,0,4, 0,1); // r15 trig ch1
      add(1,1,2,4,0, 4'h0,4'h0,4'h0, 4'h0,4'h0, 1,2,1,0,4, 0,1);
      add(1,1,2,4,0, 4'h0,4'h0,4'h0, 4'h0,4'h0, 1,2,1,0,4, 0,1);
      add(1,1,2,4,0, 4'h0,4'h2,4'h0, 4'h2,4'h0, 2,2,1,0,4, 0,1); // r18 pass age 3
      add(1,1,2,4,0, 4'h0,4'h0,4'h0, 4'h0,4'h0, 2,2,1,0,4, 0,1); // r19 nothing at hi
      add(0,1,1,3,0, 4'h0,4'h0,4'h0, 4'h0,4'h0, 2,2,1,0,4, 0,1);
      add(1,1,1,3,0, 4'h4,4'h0,4'h0, 4'h0,4'h0, 2,2,1,0,4, 0,1); // r21 window 1..3
      add(1,1,1,3,0, 4'h4,4'h0,4'h0, 4'h0,4'h0, 2,2,1,0,4, 0,1); // r22 overlap
      add(1,1,1,3,0, 4'hA,4'h4,4'h0, 4'h4,4'h0, 4,2,1,0,4, 0,1); // r23 +2 pass, trig ch1/ch3
      add(1,1,1,3,1, 4'h0,4'h0,4'h0, 4'h0,4'h0, 0,0,0,0,0, 0,1); // r24 clear
      add(1,1,1,3,0, 4'h0,4'h0,4'h0, 4'h0,4'h0, 0,0,0,0,0, 0,1);
      add(1,1,1,3,0, 4'h0,4'h0,4'h0, 4'h0,4'hA, 0,2,1,1,26,0,1); // r26 ch1+ch3 fail
      add(1,1,1,3,0, 4'h1,4'h0,4'h0, 4'h0,4'h0, 0,2,1,1,26,0,1); // r27 trig ch0
      add(1,1,1,3,0, 4'h0,4'h0,4'h0, 4'h0,4'h0, 0,2,1,1,26,0,1);
      add(1,1,1,3,0, 4'h0,4'h0,4'h0, 4'h0,4'h0, 0,2,1,1,26,0,1);
      add(1,1,1,3,1, 4'h0,4'h0,4'h0, 4'h0,4'h0, 0,0,0,0,0, 0,0); // r30 clr on failing edge
      add(1,1,1,3,0, 4'h0,4'h0,4'h0, 4'h0,4'h0, 0,0,0,0,0, 0,1);
      add(0,1,1,3,0, 4'h0,4'h0,4'h0, 4'h0,4'h0, 0,0,0,0,0, 0,1);
      add(1,0,0,0,0, 4'hF,4'h0,4'h0, 4'h0,4'h0, 0,0,0,0,0, 1,1); // r33 dly_max=0
      add(1,0,0,0,0, 4'hF,4'h0,4'h0, 4'h0,4'h0, 0,0,0,0,0, 1,1);
      add(1,0,0,0,0, 4'h0,4'hF,4'h0, 4'h0,4'h0, 0,0,0,0,0, 1,1);
      add(1,0,0,0,0, 4'h0,4'h0,4'h0, 4'h0,4'h0, 0,0,0,0,0, 1,1);
      add(0,0,0,0,0, 4'h0,4'h0,4'h0, 4'h0,4'h0, 0,0,0,0,0, 1,1);
      add(1,0,0,2,0, 4'h1,4'h0,4'h0, 4'h0,4'h0, 0,0,0,0,0, 0,1); // r38 D=2 latched
      add(1,0,0,1,0, 4'h0,4'h0,4'h0, 4'h0,4'h0, 0,0,0,0,0, 0,1); // r39 dly_max change ignored
      add(1,0,0,1,0, 4'h0,4'h1,4'h0, 4'h1,4'h0, 1,0,0,0,0, 0,1); // r40 pass at D=2
      add(0,0,0,1,0, 4'h0,4'h0,4'h0, 4'h0,4'h0, 1,0,0,0,0, 0,1);
      add(1,1,3,2,0, 4'h1,4'h0,4'h0, 4'h0,4'h0, 1,0,0,0,0, 1,1); // r42 dly_min>dly_max
      add(1,1,3,2,0, 4'h0,4'h1,4'h0, 4'h0,4'h0, 1,0,0,0,0, 1,1);

      #11;
      check_a("reset_state", zero_v);
      #1 rst_n = 1'b1;

      for (int r = 0; r < vq.size(); r++) begin
         drive_a(vq[r]);
         tick();
         check_a($sformatf("row%0d", r), vq[r]);
      end

      // Reset asserted while a window attempt is pending.
      ia.en = 0; ia.clr = 0; ia.sig_a = 0; ia.sig_b = 0; ia.sig_c = 0;
      tick();
      ia.en = 1; ia.mode = 1; ia.dly_min = 2; ia.dly_max = 4; ia.sig_a = 4'h1;
      tick();
      ia.sig_a = 4'h0;
      tick();
      #3 rst_n = 1'b0;
      #1 check_a("rst_async", zero_v);
      @(posedge clk);
      #2 rst_n = 1'b1;
      ia.sig_b = 4'h1;   // good responses that must not pass a discarded attempt
      for (int k = 0; k < 5; k++) begin
         tick();
         check_a($sformatf("post_rst%0d", k), zero_v);
      end
      ia.en = 0; ia.sig_b = 0;

      // Saturation on the narrow-counter instance.
      ib.en = 0;
      tick();
      ib.en = 1; ib.mode = 0; ib.dly_max = 1;
      for (int k = 1; k <= 5; k++) begin
         ib.sig_a = 1'b1;
         tick();
         ib.sig_a = 1'b0;
         tick();
         check_val($sformatf("sat_fail%0d", k), {62'd0, ib.fail_pulse, 1'b0} | 64'(ib.fail_cnt) << 8,
                   {62'd0, 1'b1, 1'b0} | 64'((k > 3) ? 3 : k) << 8);
      end
      check_val("sat_sticky", 64'(ib.err_sticky), 64'd1);
      check_val("sat_pass_cnt", 64'(ib.pass_cnt), 64'd0);
      check_val("sat_first_ch", 64'(ib.first_fail_ch), 64'd0);
      check_val("sat_cfg_err", 64'(ib.cfg_err), 64'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   // Guard against a stalled run.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish required finish by 200000");
      $fatal(1);
   end

endmodule
